// File: rtl/mem_store_driver_pkg.sv
// Shared definitions for the MainBus-to-MemData store path: bus width,
// wait-counter width and write-sequencer state encodings.
package mem_store_driver_pkg;
   localparam int BUS_W = 8;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;
endpackage

// File: rtl/mem_store_driver_store_fifo2.sv
// Two-entry FIFO buffering stored bytes; width is parameterised so a parity
// bit can ride along with each entry.
module store_fifo2 import mem_store_driver_pkg::*; #(
   parameter int W = BUS_W
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wr_data,
   output logic         accept,
   output logic [W-1:0] head_data,
   output logic [W-1:0] next_head,
   output logic [1:0]   count,
   output logic         full
);
   logic [W-1:0] mem [2];
   logic         head;
   logic         tail;

   assign full      = (count == 2'd2);
   assign accept    = push & (~full | pop);
   assign head_data = mem[head];
   // Entry that becomes head after a pop; with one entry left it is the byte being pushed.
   assign next_head = full ? mem[~head] : wr_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head  <= 1'b0;
         tail  <= 1'b0;
         count <= 2'd0;
      end else begin
         if (pop)
            head <= ~head;
         if (accept)
            tail <= ~tail;
         count <= count + {1'b0, accept} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         mem[tail] <= wr_data;
   end
endmodule

// File: rtl/mem_store_driver.sv
// Store path from MainBus to MemData: buffers bytes and replays them with a
// setup / write-strobe / hold sequence. STORE_PARITY_EN adds a mem_parity output.
module mem_store_driver import mem_store_driver_pkg::*; #(
   parameter int WR_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] main_bus,
   input  logic       store_n,
   output logic       stall_n,
   output logic [7:0] mem_data,
   output logic       mem_data_oe_n,
   output logic       mem_we_n,
   output logic       overflow
`ifdef STORE_PARITY_EN
   ,
   output logic       mem_parity
`endif
);
`ifdef STORE_PARITY_EN
   localparam int ENTRY_W = BUS_W + 1;
`else
   localparam int ENTRY_W = BUS_W;
`endif

   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] head_data;
   logic [ENTRY_W-1:0] next_head;
   logic [ENTRY_W-1:0] data_q;
   logic               push;
   logic               pop;
   logic               accept;
   logic               full;
   logic [1:0]         count;
   logic [CNT_W-1:0]   wait_cnt;
   state_t             state;

`ifdef STORE_PARITY_EN
   assign wr_entry   = {^main_bus, main_bus};
   assign mem_parity = data_q[BUS_W];
`else
   assign wr_entry   = main_bus;
`endif
   assign mem_data = data_q[BUS_W-1:0];
   assign push     = ~store_n;
   assign pop      = (state == ST_HOLD);
   assign stall_n  = ~full;

   store_fifo2 #(.W(ENTRY_W)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .pop       (pop),
      .wr_data   (wr_entry),
      .accept    (accept),
      .head_data (head_data),
      .next_head (next_head),
      .count     (count),
      .full      (full)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         data_q        <= '0;
         mem_data_oe_n <= 1'b1;
         mem_we_n      <= 1'b1;
         wait_cnt      <= '0;
         overflow      <= 1'b0;
      end else begin
         if (push && !accept)
            overflow <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (count != 2'd0) begin
                  state         <= ST_SETUP;
                  data_q        <= head_data;
                  mem_data_oe_n <= 1'b0;
               end
            end
            ST_SETUP: begin
               state    <= ST_STROBE;
               mem_we_n <= 1'b0;
               wait_cnt <= '0;
            end
            ST_STROBE: begin
               if (wait_cnt == CNT_W'(WR_CYCLES - 1)) begin
                  state    <= ST_HOLD;
                  mem_we_n <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            ST_HOLD: begin
               // Chain straight into the next write when anything remains after the pop.
               if (full || accept) begin
                  state  <= ST_SETUP;
                  data_q <= next_head;
               end else begin
                  state         <= ST_IDLE;
                  mem_data_oe_n <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_store_driver.sv
// Self-checking bench for mem_store_driver: directed vector table, reset and
// width corner cases, and random traffic against a queue-based reference model.
module tb_mem_store_driver;
   localparam int W = 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] main_bus = 8'h00;
   logic       store_n = 1'b1;
   logic       stall_n, oe_n, we_n, overflow;
   logic [7:0] mem_data;

   logic [7:0] bus1 = 8'h00, bus15 = 8'h00;
   logic       store1_n = 1'b1, store15_n = 1'b1;
   logic       stall1_n, oe1_n, we1_n, ovf1;
   logic       stall15_n, oe15_n, we15_n, ovf15;
   logic [7:0] md1, md15;
`ifdef STORE_PARITY_EN
   logic       par, par1, par15;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: queue holds every buffered byte, including the one being written
   logic [7:0] q[$];
   bit         busy;
   int         phase;
   logic [7:0] cur;
   bit         ovf_m;

   always #5 clk = ~clk;

   mem_store_driver #(.WR_CYCLES(W)) dut (
      .clk(clk), .reset_n(reset_n), .main_bus(main_bus), .store_n(store_n),
      .stall_n(stall_n), .mem_data(mem_data), .mem_data_oe_n(oe_n),
      .mem_we_n(we_n), .overflow(overflow)
`ifdef STORE_PARITY_EN
      , .mem_parity(par)
`endif
   );

   mem_store_driver #(.WR_CYCLES(1)) dut_w1 (
      .clk(clk), .reset_n(reset_n), .main_bus(bus1), .store_n(store1_n),
      .stall_n(stall1_n), .mem_data(md1), .mem_data_oe_n(oe1_n),
      .mem_we_n(we1_n), .overflow(ovf1)
`ifdef STORE_PARITY_EN
      , .mem_parity(par1)
`endif
   );

   mem_store_driver #(.WR_CYCLES(15)) dut_w15 (
      .clk(clk), .reset_n(reset_n), .main_bus(bus15), .store_n(store15_n),
      .stall_n(stall15_n), .mem_data(md15), .mem_data_oe_n(oe15_n),
      .mem_we_n(we15_n), .overflow(ovf15)
`ifdef STORE_PARITY_EN
      , .mem_parity(par15)
`endif
   );

   typedef struct {
      bit         rst;
      bit         push;
      logic [7:0] d;
      bit         oe;
      bit         we;
      logic [7:0] md;
      bit         st;
      bit         ov;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      busy  = 0;
      phase = 0;
      cur   = 8'h00;
      ovf_m = 0;
   endtask

   task automatic model_edge(input bit p, input logic [7:0] d);
      int old;
      bit pop, acc;
      old = q.size();
      pop = busy && (phase == W + 1);
      acc = p && (old < 2 || pop);
      if (p && !acc) ovf_m = 1;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(d);
      if (pop) begin
         if (q.size() > 0) begin
            phase = 0;
            cur   = q[0];
         end else begin
            busy = 0;
         end
      end else if (busy) begin
         phase++;
      end else if (old > 0) begin
         busy  = 1;
         phase = 0;
         cur   = q[0];
      end
   endtask

   task automatic cmp_model(input string tag);
      chk({tag, ".oe_n"}, int'(oe_n), int'(!busy));
      chk({tag, ".we_n"}, int'(we_n), int'(!(busy && phase >= 1 && phase <= W)));
      chk({tag, ".mem_data"}, int'(mem_data), int'(cur));
      chk({tag, ".stall_n"}, int'(stall_n), int'(q.size() != 2));
      chk({tag, ".overflow"}, int'(overflow), int'(ovf_m));
`ifdef STORE_PARITY_EN
      chk({tag, ".parity"}, int'(par), int'(^cur));
`endif
   endtask

   // drive at the falling edge, model on the rising edge, sample at the next falling edge
   task automatic step(input bit p, input logic [7:0] d);
      store_n  = ~p;
      main_bus = d;
      @(posedge clk);
      model_edge(p, d);
      @(negedge clk);
      store_n = 1'b1;
   endtask

   task automatic do_reset(input bit check);
      reset_n = 1'b0;
      store_n = 1'b1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      if (check) begin
         chk("rst.oe_n", int'(oe_n), 1);
         chk("rst.we_n", int'(we_n), 1);
         chk("rst.stall_n", int'(stall_n), 1);
         chk("rst.overflow", int'(overflow), 0);
         chk("rst.mem_data", int'(mem_data), 0);
      end
      reset_n = 1'b1;
   endtask

   function automatic void runs(input bit s[64], output int len, output int per);
      int a, b;
      a = -1; b = -1; len = 0;
      for (int i = 0; i < 64; i++)
         if (a < 0 && !s[i]) a = i;
      if (a >= 0) begin
         for (int i = a; i < 64 && !s[i]; i++) len++;
         for (int i = a + len; i < 64; i++)
            if (b < 0 && !s[i]) b = i;
      end
      per = (a >= 0 && b >= 0) ? b - a : -1;
   endfunction

   initial begin
      bit s1[64], s15[64];
      int len, per, k;

      // single write, overflow on three back-to-back pushes, push on the HOLD-exit edge
      tbl.push_back('{1, 1, 8'hA5, 1, 1, 8'h00, 1, 0});
      tbl.push_back('{0, 0, 8'h00, 0, 1, 8'hA5, 1, 0});
      tbl.push_back('{0, 0, 8'h00, 0, 0, 8'hA5, 1, 0});
      tbl.push_back('{0, 0, 8'h00, 0, 0, 8'hA5, 1, 0});
      tbl.push_back('{0, 0, 8'h00, 0, 1, 8'hA5, 1, 0});
      tbl.push_back('{0, 0, 8'h00, 1, 1, 8'hA5, 1, 0});
      tbl.push_back('{0, 0, 8'h00, 1, 1, 8'hA5, 1, 0});
      tbl.push_back('{1, 1, 8'h11, 1, 1, 8'h00, 1, 0});
      tbl.push_back('{0, 1, 8'h22, 0, 1, 8'h11, 0, 0});
      tbl.push_back('{0, 1, 8'h33, 0, 0, 8'h11, 0, 1});
      tbl.push_back('{0, 0, 8'h00, 0, 0, 8'h11, 0, 1});
      tbl.push_back('{0, 0, 8'h00, 0, 1, 8'h11, 0, 1});
      tbl.push_back('{0, 0, 8'h00, 0, 1, 8'h22, 1, 1});
      tbl.push_back('{0, 0, 8'h00, 0, 0, 8'h22, 1, 1});
      tbl.push_back('{0, 0, 8'h00, 0, 0, 8'h22, 1, 1});
      tbl.push_back('{0, 0, 8'h00, 0, 1, 8'h22, 1, 1});
      tbl.push_back('{0, 0, 8'h00, 1, 1, 8'h22, 1, 1});
      tbl.push_back('{1, 1, 8'h11, 1, 1, 8'h00, 1, 0});
      tbl.push_back('{0, 1, 8'h22, 0, 1, 8'h11, 0, 0});
      tbl.push_back('{0, 0, 8'h00, 0, 0, 8'h11, 0, 0});
      tbl.push_back('{0, 0, 8'h00, 0, 0, 8'h11, 0, 0});
      tbl.push_back('{0, 0, 8'h00, 0, 1, 8'h11, 0, 0});
      tbl.push_back('{0, 1, 8'h44, 0, 1, 8'h22, 0, 0});
      tbl.push_back('{0, 0, 8'h00, 0, 0, 8'h22, 0, 0});
      tbl.push_back('{0, 0, 8'h00, 0, 0, 8'h22, 0, 0});
      tbl.push_back('{0, 0, 8'h00, 0, 1, 8'h22, 0, 0});
      tbl.push_back('{0, 0, 8'h00, 0, 1, 8'h44, 1, 0});
      tbl.push_back('{0, 0, 8'h00, 0, 0, 8'h44, 1, 0});
      tbl.push_back('{0, 0, 8'h00, 0, 0, 8'h44, 1, 0});
      tbl.push_back('{0, 0, 8'h00, 0, 1, 8'h44, 1, 0});
      tbl.push_back('{0, 0, 8'h00, 1, 1, 8'h44, 1, 0});

      @(negedge clk);
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) do_reset(i == 0);
         step(tbl[i].push, tbl[i].d);
         chk($sformatf("vec%0d.oe_n", i), int'(oe_n), int'(tbl[i].oe));
         chk($sformatf("vec%0d.we_n", i), int'(we_n), int'(tbl[i].we));
         chk($sformatf("vec%0d.mem_data", i), int'(mem_data), int'(tbl[i].md));
         chk($sformatf("vec%0d.stall_n", i), int'(stall_n), int'(tbl[i].st));
         chk($sformatf("vec%0d.overflow", i), int'(overflow), int'(tbl[i].ov));
      end

      // reset asserted in the middle of the write strobe
      do_reset(0);
      step(1, 8'h5A);
      k = 0;
      while (we_n !== 1'b0 && k < 10) begin
         step(0, 8'h00);
         k++;
      end
      chk("midrst.reach_strobe", int'(we_n), 0);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst.we_n_async", int'(we_n), 1);
      chk("midrst.oe_n_async", int'(oe_n), 1);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) step(0, 8'h00);
      chk("midrst.stall_n", int'(stall_n), 1);
      chk("midrst.oe_idle", int'(oe_n), 1);
      cmp_model("midrst");

`ifdef STORE_PARITY_EN
      do_reset(0);
      step(1, 8'h07);
      step(0, 8'h00);
      chk("par07.parity", int'(par), 1);
      chk("par07.data", int'(mem_data), 8'h07);
      for (int i = 0; i < 6; i++) step(0, 8'h00);
      step(1, 8'h03);
      step(0, 8'h00);
      chk("par03.parity", int'(par), 0);
      chk("par03.data", int'(mem_data), 8'h03);
`endif

      // strobe width and per-byte period on the WR_CYCLES=1 and 15 builds
      do_reset(0);
      store1_n = 1'b0; bus1 = 8'h81; store15_n = 1'b0; bus15 = 8'hF1;
      @(negedge clk);
      bus1 = 8'h82; bus15 = 8'hF2;
      @(negedge clk);
      store1_n = 1'b1; store15_n = 1'b1;
      for (int i = 0; i < 64; i++) begin
         s1[i]  = we1_n;
         s15[i] = we15_n;
         @(negedge clk);
      end
      runs(s1, len, per);
      chk("w1.we_width", len, 1);
      chk("w1.period", per, 3);
      runs(s15, len, per);
      chk("w15.we_width", len, 15);
      chk("w15.period", per, 17);
      chk("w1.overflow", int'(ovf1), 0);
      chk("w15.oe_idle", int'(oe15_n), 1);

      // random traffic against the reference model, alternating light and heavy load
      do_reset(0);
      for (int i = 0; i < 400; i++) begin
         int pct;
         pct = ((i / 50) % 2 == 1) ? 85 : 25;
         step($urandom_range(0, 99) < pct, 8'($urandom));
         cmp_model($sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
